toggle_hs_receiver: RTL

- Responder end of a 2-phase (toggle) request/acknowledge handshake.
- An initiator signals each event by flipping `req_tgl`. This block synchronises the request, presents the event to a local consumer as a valid/ready handshake, and acknowledges it by flipping `ack_tgl`.
- It also counts accepted events and flags protocol violations.
- It sits between a toggle-based event source (a T-flip-flop style producer) and synchronous downstream logic.

---
 rtl/toggle_hs_receiver.sv | 86 ++++++++
 1 files changed

// File: rtl/toggle_hs_receiver.sv
// toggle_hs_receiver: responder side of a 2-phase toggle handshake, presenting each
// synchronised request as a valid/ready event, counting accepts and flagging withdrawals.
module toggle_hs_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_tgl,
    input  logic                 ready,
    output logic                 ack_tgl,
    output logic                 evt_valid,
    output logic                 evt_pulse,
    output logic [CNT_WIDTH-1:0] evt_count,
    output logic                 cnt_sat,
    output logic                 err_lost
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t               state_q, state_d;
    logic                 req_s, pending;
    logic                 ack_q, ack_d, pulse_q, pulse_d, sat_q, sat_d, err_q, err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign req_s = req_tgl;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk)
                sync_q <= reset ? '0 : (sync_q << 1) | SYNC_STAGES'(req_tgl);
            assign req_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign pending = req_s ^ ack_q;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        err_d   = err_q;
        if (state_q == S_IDLE) begin
            if (pending) begin
                state_d = S_WAIT;
                pulse_d = 1'b1;
            end
        end else if (!pending) begin
            // request level returned before acceptance: the event was withdrawn
            err_d   = 1'b1;
            state_d = S_IDLE;
        end else if (ready) begin
            ack_d   = ~ack_q;
            cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
            sat_d   = sat_q | (&cnt_d);
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign ack_tgl   = ack_q;
    assign evt_valid = (state_q == S_WAIT);
    assign evt_pulse = pulse_q;
    assign evt_count = cnt_q;
    assign cnt_sat   = sat_q;
    assign err_lost  = err_q;
endmodule
